modulo_condicionador_entrada: RTL

//  Input-conditioning stage upstream of the game top level. Synchronises the raw mode

---
 rtl/modulo_jogo_pkg.sv | 29 ++
 rtl/modulo_sincronizador.sv | 27 ++
 rtl/modulo_condicionador_entrada.sv | 125 ++++++++++++
 3 files changed

// File: rtl/modulo_jogo_pkg.sv
// Shared definitions for the game input path: debounce FSM encoding, mode codes
// and the legal coordinate window of the board.
package modulo_jogo_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_DEB = 2'd1,
        HELD      = 2'd2,
        REL_DEB   = 2'd3
    } deb_state_t;

    localparam logic [1:0] MODE_CLEAR    = 2'b00;
    localparam logic [1:0] MODE_ATTACK   = 2'b01;
    localparam logic [1:0] MODE_POSITION = 2'b10;
    localparam logic [1:0] MODE_STATUS   = 2'b11;

    localparam logic [2:0] ROW_MAX = 3'd6;
    localparam logic [2:0] COL_MAX = 3'd4;

    // Coordinate is {row[2:0], col[2:0]}.
    function automatic logic coord_in_range(input logic [5:0] coord);
        return (coord[5:3] <= ROW_MAX) && (coord[2:0] <= COL_MAX);
    endfunction

    function automatic logic mode_needs_coord(input logic [1:0] mode);
        return (mode == MODE_ATTACK) || (mode == MODE_POSITION);
    endfunction

endpackage

// File: rtl/modulo_sincronizador.sv
// Multi-flop synchroniser for asynchronous switch/button inputs, with a
// per-instance reset value so idle-high signals come out of reset inactive.
module modulo_sincronizador #(
    parameter int              WIDTH   = 1,
    parameter int              STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < STAGES; i++) stage[i] <= RST_VAL;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/modulo_condicionador_entrada.sv
// Input conditioning for the game: synchronises switches and the confirm button,
// debounces the button and emits one mode-strobe/coordinate event per press.
module modulo_condicionador_entrada
    import modulo_jogo_pkg::*;
#(
    parameter int DEB_CYCLES  = 50000,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       button_confirmation,
    input  logic [1:0] hh1,
    input  logic [5:0] hh2,
    output logic [1:0] hh1_s,
    output logic [5:0] hh2_s,
    output logic       confirm_pulse,
    output logic [3:0] sel_state,
    output logic       err_pulse,
    output logic [1:0] mode_lat,
    output logic [5:0] coord_lat,
    output logic       coord_valid,
    output logic       busy
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic btn_s;
    logic pressed;
    deb_state_t state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [1:0] m0, m0_next;
    logic fire;

    modulo_sincronizador #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_btn (
        .clk(clk), .clr(clr), .d(button_confirmation), .q(btn_s)
    );

    modulo_sincronizador #(.WIDTH(2), .STAGES(SYNC_STAGES), .RST_VAL(2'b00)) u_sync_hh1 (
        .clk(clk), .clr(clr), .d(hh1), .q(hh1_s)
    );

    modulo_sincronizador #(.WIDTH(6), .STAGES(SYNC_STAGES), .RST_VAL(6'b0)) u_sync_hh2 (
        .clk(clk), .clr(clr), .d(hh2), .q(hh2_s)
    );

    // The press level is registered once more so the FSM sees a clean flop output.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        m0_next    = m0;
        fire       = 1'b0;
        case (state)
            IDLE: begin
                if (pressed) begin
                    state_next = PRESS_DEB;
                    cnt_next   = '0;
                    m0_next    = hh1_s;
                end
            end
            PRESS_DEB: begin
                if (!pressed || (hh1_s != m0)) begin
                    state_next = IDLE;
                end else if (cnt == DEB_LAST) begin
                    state_next = HELD;
                    fire       = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_next = REL_DEB;
                    cnt_next   = '0;
                end
            end
            REL_DEB: begin
                if (pressed) begin
                    state_next = HELD;
                end else if (cnt == DEB_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state         <= REL_DEB;
            cnt           <= '0;
            m0            <= 2'b00;
            pressed       <= 1'b0;
            confirm_pulse <= 1'b0;
            sel_state     <= 4'b0000;
            err_pulse     <= 1'b0;
            mode_lat      <= 2'b00;
            coord_lat     <= 6'b0;
            coord_valid   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            m0            <= m0_next;
            pressed       <= ~btn_s;
            confirm_pulse <= fire;
            sel_state     <= 4'b0000;
            err_pulse     <= 1'b0;
            busy          <= (state_next != IDLE);
            if (fire) begin
                mode_lat    <= hh1_s;
                coord_lat   <= hh2_s;
                coord_valid <= coord_in_range(hh2_s);
                // CLEAR/STATUS act on the whole board, so the coordinate is irrelevant.
                if (!mode_needs_coord(hh1_s) || coord_in_range(hh2_s))
                    sel_state <= 4'b0001 << hh1_s;
                else
                    err_pulse <= 1'b1;
            end
        end
    end

endmodule
